// File: rtl/ascii_pkg.sv
// Character codes, FSM states and character classes shared by the ASCII
// number-entry path (top level and character classifier).
package ascii_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'd48;
  localparam logic [7:0] ASCII_NINE  = 8'd57;
  localparam logic [7:0] ASCII_BS    = 8'd8;
  localparam logic [7:0] ASCII_ESC   = 8'd27;
  localparam logic [7:0] ASCII_CR    = 8'd13;
  localparam logic [7:0] ASCII_LF    = 8'd10;
  localparam logic [7:0] ASCII_MINUS = 8'd45;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    CONVERT,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    DIGIT,
    BKSP,
    CLEAR,
    TERM,
    MINUS,
    OTHER
  } char_class_t;

endpackage

// File: rtl/ascii_char_class.sv
// Combinational character classifier. Codes with any bit set above bit 7 are
// OTHER. '-' is classified as MINUS only when ASCII_NEG_EN is defined.
module ascii_char_class
  import ascii_pkg::*;
#(
  parameter int CHAR_W = 12
) (
  input  logic [CHAR_W-1:0] ascii_input,
  output char_class_t       char_class,
  output logic [3:0]        digit
);

  logic [7:0] code;
  logic       upper_clear;

  assign code = ascii_input[7:0];

  generate
    if (CHAR_W > 8) begin : g_upper
      assign upper_clear = ~|ascii_input[CHAR_W-1:8];
    end else begin : g_no_upper
      assign upper_clear = 1'b1;
    end
  endgenerate

  // '0'..'9' are 0x30..0x39, so the low nibble is already the digit value.
  assign digit = code[3:0];

  always_comb begin
    char_class = OTHER;
    if (upper_clear) begin
      if (code >= ASCII_ZERO && code <= ASCII_NINE) begin
        char_class = DIGIT;
      end else if (code == ASCII_BS) begin
        char_class = BKSP;
      end else if (code == ASCII_ESC) begin
        char_class = CLEAR;
      end else if (code == ASCII_CR || code == ASCII_LF) begin
        char_class = TERM;
      end
`ifdef ASCII_NEG_EN
      else if (code == ASCII_MINUS) begin
        char_class = MINUS;
      end
`endif
    end
  end

endmodule

// File: rtl/ascii_number_accumulator.sv
// Multi-digit ASCII number entry: digit buffer with backspace/clear editing and
// an iterative decimal-to-binary conversion. ASCII_NEG_EN adds a leading '-' sign.
module ascii_number_accumulator
  import ascii_pkg::*;
#(
  parameter int  CHAR_W     = 12,
  parameter int  DATA_W     = 32,
  parameter int  MAX_DIGITS = 9,
  localparam int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              char_valid,
  input  logic [CHAR_W-1:0] ascii_input,
  output logic              char_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ack,
  output logic [CNT_W-1:0]  digit_count,
  output logic              overflow,
  output logic              drop
);

  localparam int ACC_W = DATA_W + 4;

  state_t            state;
  char_class_t       char_class;
  logic [3:0]        char_digit;
  logic [3:0]        digit_buf [MAX_DIGITS];
  logic [CNT_W-1:0]  conv_idx;
  logic [DATA_W-1:0] acc;
  logic              ovf_sticky;
  logic              sign;

  logic              accept;
  logic              full;
  logic              buf_we;
  logic              last_digit;
  logic [ACC_W-1:0]  acc_wide;
  logic              conv_ovf;
  logic [DATA_W-1:0] result_value;
  logic              result_ovf;

  ascii_char_class #(
    .CHAR_W(CHAR_W)
  ) u_char_class (
    .ascii_input(ascii_input),
    .char_class (char_class),
    .digit      (char_digit)
  );

  assign accept     = char_valid & char_ready;
  assign full       = (digit_count == CNT_W'(MAX_DIGITS));
  assign buf_we     = accept && (char_class == DIGIT) && !full;
  assign last_digit = (conv_idx == digit_count - CNT_W'(1));

  // acc is kept modulo 2^DATA_W; acc*10+9 always fits in the 4 extra bits,
  // so any carry out of DATA_W means the true value has overflowed.
  assign acc_wide = ACC_W'(acc) * ACC_W'(10) + ACC_W'(digit_buf[conv_idx]);

`ifdef ASCII_NEG_EN
  localparam logic [DATA_W-1:0] NEG_LIMIT = {1'b1, {(DATA_W-1){1'b0}}};
`endif

  always_comb begin
    conv_ovf     = ovf_sticky | (|acc_wide[ACC_W-1:DATA_W]);
    result_value = acc_wide[DATA_W-1:0];
    result_ovf   = conv_ovf;
`ifdef ASCII_NEG_EN
    if (sign) begin
      result_value = -acc_wide[DATA_W-1:0];
      result_ovf   = conv_ovf | (acc_wide[DATA_W-1:0] > NEG_LIMIT);
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (buf_we) begin
      digit_buf[digit_count] <= char_digit;
    end
  end

  always_ff @(posedge clock) begin
    drop <= 1'b0;
    if (reset) begin
      state       <= IDLE;
      digit_count <= '0;
      conv_idx    <= '0;
      acc         <= '0;
      ovf_sticky  <= 1'b0;
      sign        <= 1'b0;
      data_out    <= '0;
      overflow    <= 1'b0;
      data_valid  <= 1'b0;
      char_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE, ENTRY: begin
          if (accept) begin
            case (char_class)
              DIGIT: begin
                if (full) begin
                  drop <= 1'b1;
                end else begin
                  digit_count <= digit_count + CNT_W'(1);
                  state       <= ENTRY;
                end
              end
              BKSP: begin
                if (digit_count != '0) begin
                  digit_count <= digit_count - CNT_W'(1);
                  if (digit_count == CNT_W'(1) && !sign) state <= IDLE;
                end else begin
                  // Empty buffer: drop a lone sign, otherwise nothing changes.
                  sign  <= 1'b0;
                  state <= IDLE;
                end
              end
              CLEAR: begin
                digit_count <= '0;
                sign        <= 1'b0;
                state       <= IDLE;
              end
              TERM: begin
                if (digit_count != '0) begin
                  state      <= CONVERT;
                  char_ready <= 1'b0;
                  conv_idx   <= '0;
                  acc        <= '0;
                  ovf_sticky <= 1'b0;
                end else begin
                  sign  <= 1'b0;
                  state <= IDLE;
                end
              end
              MINUS: begin
                if (state == IDLE && !sign) begin
                  sign  <= 1'b1;
                  state <= ENTRY;
                end
              end
              default: ;
            endcase
          end
        end
        CONVERT: begin
          acc        <= acc_wide[DATA_W-1:0];
          ovf_sticky <= conv_ovf;
          conv_idx   <= conv_idx + CNT_W'(1);
          if (last_digit) begin
            state       <= DONE;
            data_out    <= result_value;
            overflow    <= result_ovf;
            data_valid  <= 1'b1;
            digit_count <= '0;
            sign        <= 1'b0;
          end
        end
        DONE: begin
          if (data_ack) begin
            state      <= IDLE;
            data_valid <= 1'b0;
            char_ready <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          char_ready <= 1'b1;
          data_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_number_accumulator.sv
// Self-checking bench: vector table, hand sequences for latency/drop/reset/overflow,
// and randomized streams against a queue-based model. Honours ASCII_NEG_EN.
module tb_ascii_number_accumulator;
  import ascii_pkg::*;

  localparam int CHAR_W  = 12;
  localparam int DATA_W  = 32;
  localparam int MAXD    = 9;
  localparam int CNT_W   = $clog2(MAXD + 1);
  localparam int S_W     = 8;
  localparam int S_MAXD  = 4;
  localparam int S_CNT_W = $clog2(S_MAXD + 1);

  logic              clock = 1'b0;
  logic              reset;
  logic              char_valid;
  logic [CHAR_W-1:0] ascii_input;
  logic              char_ready;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              data_ack;
  logic [CNT_W-1:0]  digit_count;
  logic              overflow;
  logic              drop;

  logic               s_char_valid;
  logic [CHAR_W-1:0]  s_ascii_input;
  logic               s_char_ready;
  logic [S_W-1:0]     s_data_out;
  logic               s_data_valid;
  logic               s_data_ack;
  logic [S_CNT_W-1:0] s_digit_count;
  logic               s_overflow;
  logic               s_drop;

  always #5 clock = ~clock;

  ascii_number_accumulator #(.CHAR_W(CHAR_W), .DATA_W(DATA_W), .MAX_DIGITS(MAXD)) u_dut (
    .clock(clock), .reset(reset), .char_valid(char_valid), .ascii_input(ascii_input),
    .char_ready(char_ready), .data_out(data_out), .data_valid(data_valid),
    .data_ack(data_ack), .digit_count(digit_count), .overflow(overflow), .drop(drop)
  );

  ascii_number_accumulator #(.CHAR_W(CHAR_W), .DATA_W(S_W), .MAX_DIGITS(S_MAXD)) u_small (
    .clock(clock), .reset(reset), .char_valid(s_char_valid), .ascii_input(s_ascii_input),
    .char_ready(s_char_ready), .data_out(s_data_out), .data_valid(s_data_valid),
    .data_ack(s_data_ack), .digit_count(s_digit_count), .overflow(s_overflow), .drop(s_drop)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  // ---------------- main-instance drivers ----------------
  task automatic send(input logic [CHAR_W-1:0] c);
    int n;
    n = 0;
    @(negedge clock);
    char_valid  = 1'b1;
    ascii_input = c;
    while (!char_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!char_ready) check("send_ready_timeout", 64'(char_ready), 64'd1);
    @(posedge clock);
    #1;
    char_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(CHAR_W'(s[i]));
  endtask

  task automatic wait_result(input int budget, output bit seen, output int edges);
    edges = 0;
    while (!data_valid && edges < budget) begin
      @(posedge clock);
      #1;
      edges++;
    end
    seen = data_valid;
  endtask

  task automatic ack_result(input int delay);
    for (int i = 0; i < delay; i++) begin
      @(posedge clock);
      #1;
      check("valid_held_before_ack", 64'(data_valid), 64'd1);
    end
    @(negedge clock);
    data_ack = 1'b1;
    @(posedge clock);
    #1;
    data_ack = 1'b0;
    check("ack_valid_low", 64'(data_valid), 64'd0);
    check("ack_ready_high", 64'(char_ready), 64'd1);
  endtask

  task automatic expect_result(input string name, input logic [31:0] val, input bit ovf, input int lat);
    bit seen;
    int edges;
    wait_result(MAXD + 4, seen, edges);
    check({name, "_valid"}, 64'(seen), 64'd1);
    if (lat >= 0) check({name, "_latency"}, 64'(edges), 64'(lat));
    check({name, "_data"}, 64'(data_out), 64'(val));
    check({name, "_ovf"}, 64'(overflow), 64'(ovf));
    check({name, "_count"}, 64'(digit_count), 64'd0);
    $display("txn %s: data_out=0x%0h overflow=%0d latency=%0d", name, data_out, overflow, edges);
  endtask

  task automatic expect_no_result(input string name);
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
    end
    check({name, "_no_valid"}, 64'(data_valid), 64'd0);
    check({name, "_ready"}, 64'(char_ready), 64'd1);
    check({name, "_count"}, 64'(digit_count), 64'd0);
    $display("txn %s: no result", name);
  endtask

  // ---------------- small-instance driver ----------------
  task automatic s_entry(input string name, input string s, input logic [7:0] val, input bit ovf);
    int n;
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clock);
      s_char_valid  = 1'b1;
      s_ascii_input = CHAR_W'(s[i]);
      @(posedge clock);
      #1;
      s_char_valid = 1'b0;
    end
    n = 0;
    while (!s_data_valid && n < S_MAXD + 4) begin
      @(posedge clock);
      #1;
      n++;
    end
    check({name, "_valid"}, 64'(s_data_valid), 64'd1);
    check({name, "_data"}, 64'(s_data_out), 64'(val));
    check({name, "_ovf"}, 64'(s_overflow), 64'(ovf));
    $display("txn %s: data_out=%0d overflow=%0d", name, s_data_out, s_overflow);
    @(negedge clock);
    s_data_ack = 1'b1;
    @(posedge clock);
    #1;
    s_data_ack = 1'b0;
  endtask

  // ---------------- reference model ----------------
  int unsigned m_digs[$];
  bit          m_sign;

  task automatic model_step(input logic [CHAR_W-1:0] c, output bit fire, output bit drop_exp,
                            output logic [31:0] val, output bit ovf, output int n);
    longint unsigned mag;
    fire = 0; drop_exp = 0; val = '0; ovf = 0; n = 0;
    if (c > 255) return;
    if (c >= 48 && c <= 57) begin
      if (m_digs.size() < MAXD) m_digs.push_back(int'(c) - 48);
      else drop_exp = 1;
    end else if (c == 8) begin
      if (m_digs.size() > 0) void'(m_digs.pop_back());
      else m_sign = 0;
    end else if (c == 27) begin
      m_digs.delete();
      m_sign = 0;
    end else if (c == 13 || c == 10) begin
      if (m_digs.size() > 0) begin
        mag = 0;
        foreach (m_digs[i]) mag = mag * 10 + m_digs[i];
        n    = m_digs.size();
        fire = 1;
        if (m_sign) begin
          val = 32'(-mag);
          ovf = (mag > 64'h8000_0000);
        end else begin
          val = 32'(mag);
          ovf = (mag > 64'hFFFF_FFFF);
        end
        m_digs.delete();
      end
      m_sign = 0;
    end
`ifdef ASCII_NEG_EN
    else if (c == 45) begin
      if (m_digs.size() == 0 && !m_sign) m_sign = 1;
    end
`endif
  endtask

  typedef struct {
    string       keys;
    bit          has_result;
    logic [31:0] value;
    bit          ovf;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    logic [CHAR_W-1:0] c;
    bit fire, drop_exp, ovf, seen;
    logic [31:0] val;
    int n, edges, guard;

    vecs[0] = '{"123\015", 1'b1, 32'd123, 1'b0};
    vecs[1] = '{"45\0107\015", 1'b1, 32'd47, 1'b0};
    vecs[2] = '{"12\03334\012", 1'b1, 32'd34, 1'b0};
    vecs[3] = '{"\010\015", 1'b0, 32'd0, 1'b0};
    vecs[4] = '{"56\033\015", 1'b0, 32'd0, 1'b0};
    vecs[5] = '{"7x\010\0108\015", 1'b1, 32'd8, 1'b0};
    vecs[6] = '{"0000042\015", 1'b1, 32'd42, 1'b0};
    vecs[7] = '{"A1B2\012", 1'b1, 32'd12, 1'b0};

    reset = 1'b1; char_valid = 1'b0; ascii_input = '0; data_ack = 1'b0;
    s_char_valid = 1'b0; s_ascii_input = '0; s_data_ack = 1'b0;
    m_sign = 0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("reset_data_out", 64'(data_out), 64'd0);
    check("reset_data_valid", 64'(data_valid), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);
    check("reset_drop", 64'(drop), 64'd0);
    check("reset_count", 64'(digit_count), 64'd0);
    check("reset_ready", 64'(char_ready), 64'd1);

    // Latency and hold-until-ack
    send_str("123\015");
    expect_result("lat123", 32'd123, 1'b0, 3);
    ack_result(2);

    // Vector table
    foreach (vecs[i]) begin
      send_str(vecs[i].keys);
      if (vecs[i].has_result) begin
        expect_result($sformatf("vec%0d", i), vecs[i].value, vecs[i].ovf, -1);
        ack_result(1);
      end else begin
        expect_no_result($sformatf("vec%0d", i));
      end
    end

    // Buffer full: tenth digit dropped with a one-cycle pulse
    for (int i = 0; i < MAXD; i++) send("9");
    check("full_count", 64'(digit_count), 64'(MAXD));
    check("full_no_drop", 64'(drop), 64'd0);
    send("9");
    check("drop_pulse", 64'(drop), 64'd1);
    check("drop_count", 64'(digit_count), 64'(MAXD));
    @(posedge clock);
    #1;
    check("drop_one_cycle", 64'(drop), 64'd0);
    send("\015");
    expect_result("nines", 32'd999999999, 1'b0, MAXD);
    ack_result(0);

    // Upper-bit code ignored; characters offered during CONVERT/DONE not consumed
    send("2");
    send(12'h131);
    check("upper_ignored_count", 64'(digit_count), 64'd1);
    send("5");
    send("\015");
    @(negedge clock);
    char_valid  = 1'b1;
    ascii_input = CHAR_W'("7");
    check("convert_not_ready", 64'(char_ready), 64'd0);
    expect_result("hold25", 32'd25, 1'b0, -1);
    @(posedge clock);
    #1;
    check("done_not_ready", 64'(char_ready), 64'd0);
    char_valid = 1'b0;
    ack_result(0);
    check("not_consumed_count", 64'(digit_count), 64'd0);

    // Reset during the second CONVERT cycle
    send_str("987\015");
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("midreset_data_out", 64'(data_out), 64'd0);
    check("midreset_valid", 64'(data_valid), 64'd0);
    check("midreset_ovf", 64'(overflow), 64'd0);
    check("midreset_count", 64'(digit_count), 64'd0);
    check("midreset_ready", 64'(char_ready), 64'd1);
    expect_no_result("midreset");

    // DATA_W=8 instance: overflow boundaries
    s_entry("s255", "255\015", 8'd255, 1'b0);
    s_entry("s256", "256\015", 8'd0, 1'b1);
    s_entry("s300", "300\015", 8'd44, 1'b1);
    s_entry("s9999", "9999\015", 8'(9999 % 256), 1'b1);

`ifdef ASCII_NEG_EN
    send_str("-42\015");
    expect_result("neg42", 32'hFFFF_FFD6, 1'b0, 2);
    ack_result(0);
    send_str("-\015");
    expect_no_result("neg_empty");
    send_str("5\015");
    expect_result("after_neg", 32'd5, 1'b0, 1);
    ack_result(0);
    send_str("-\0107\015");
    expect_result("neg_bs", 32'd7, 1'b0, 1);
    ack_result(0);
    s_entry("sneg128", "-128\015", 8'h80, 1'b0);
    s_entry("sneg129", "-129\015", 8'd127, 1'b1);
`endif

    // Randomized streams against the model
    m_digs.delete();
    m_sign = 0;
    for (int t = 0; t < 25; t++) begin
      fire  = 0;
      guard = 0;
      while (!fire && guard < 40) begin
        case ($urandom_range(0, 19))
          10, 11:  c = CHAR_W'(8);
          12:      c = CHAR_W'(27);
          13:      c = CHAR_W'(13);
          14:      c = CHAR_W'(10);
          15:      c = CHAR_W'(45);
          16:      c = CHAR_W'("x");
          17:      c = 12'h135;
          18:      c = CHAR_W'(" ");
          19:      c = CHAR_W'("9");
          default: c = CHAR_W'(48 + $urandom_range(0, 9));
        endcase
        model_step(c, fire, drop_exp, val, ovf, n);
        send(c);
        check("rand_drop", 64'(drop), 64'(drop_exp));
        if (!fire) check("rand_count", 64'(digit_count), 64'(m_digs.size()));
        guard++;
      end
      if (fire) begin
        wait_result(MAXD + 4, seen, edges);
        check("rand_valid", 64'(seen), 64'd1);
        check("rand_latency", 64'(edges), 64'(n));
        check("rand_data", 64'(data_out), 64'(val));
        check("rand_ovf", 64'(overflow), 64'(ovf));
        $display("txn rand%0d: digits=%0d data_out=0x%0h expected=0x%0h", t, n, data_out, val);
        ack_result($urandom_range(0, 3));
      end else begin
        send(CHAR_W'(27));
        m_digs.delete();
        m_sign = 0;
        $display("txn rand%0d: cleared without terminator", t);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
